// File: rtl/r2add_p_if.sv
// Framed digit-serial handshake bundle for the r2add_p online adder.
// Each lane occupies two bits of i_x/i_y/o_s; master drives digits, slave returns results.
interface r2add_p_if #(
    parameter int CH = 1
);
    logic            i_valid;
    logic            i_ready;
    logic            i_sub;
    logic [2*CH-1:0] i_x;
    logic [2*CH-1:0] i_y;
    logic            o_valid;
    logic            o_first;
    logic            o_last;
    logic [2*CH-1:0] o_s;
    logic            o_err;

    modport slave (
        input  i_valid, i_sub, i_x, i_y,
        output i_ready, o_valid, o_first, o_last, o_s, o_err
    );

    modport master (
        output i_valid, i_sub, i_x, i_y,
        input  i_ready, o_valid, o_first, o_last, o_s, o_err
    );
endinterface

// File: rtl/r2add_p.sv
// Radix-2 online (MSD-first) signed-digit adder/subtractor, CH lanes, N_DIGITS per frame.
// Optional sticky illegal-digit detector enabled by defining R2ADD_P_ERRCHK_EN.
module r2add_p #(
    parameter int CH       = 1,
    parameter int N_DIGITS = 8
) (
    input  logic      clk,
    input  logic      reset,
    r2add_p_if.slave  bus
);
    localparam int PW = $clog2(N_DIGITS + 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH} state_t;

    state_t          r_state, w_state_next;
    logic [PW-1:0]   r_pos, w_pos_next, w_pos_inc;
    logic            r_fl, w_fl_next;
    logic            r_sub;

    logic            w_ready, w_accept, w_step, w_out_step;
    logic            w_first, w_last, w_flush, w_z_clr, w_sub;

    logic            r_o_valid, r_o_first, r_o_last;
    logic [2*CH-1:0] r_s, w_s_next;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_pos   <= '0;
            r_fl    <= 1'b0;
            r_sub   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_pos   <= w_pos_next;
            r_fl    <= w_fl_next;
            if (w_accept && r_state == S_IDLE)
                r_sub <= bus.i_sub;
        end
    end

    assign w_pos_inc = r_pos + 1'b1;

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        w_pos_next   = r_pos;
        w_fl_next    = r_fl;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_pos_next   = PW'(1);
                    w_state_next = S_RUN;
                end
            end
            S_RUN: begin
                if (w_accept) begin
                    w_pos_next = w_pos_inc;
                    if (w_pos_inc == PW'(N_DIGITS)) begin
                        w_state_next = S_FLUSH;
                        w_fl_next    = 1'b0;
                    end
                end
            end
            S_FLUSH: begin
                w_fl_next = 1'b1;
                if (r_fl) begin
                    w_state_next = S_IDLE;
                    w_fl_next    = 1'b0;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Output / control decode
    always_comb begin
        w_ready    = (r_state != S_FLUSH);
        w_accept   = bus.i_valid && w_ready;
        w_flush    = (r_state == S_FLUSH);
        w_step     = w_accept || w_flush;
        w_out_step = w_step && (r_state != S_IDLE);
        w_first    = w_accept && (r_state == S_RUN) && (r_pos == PW'(1));
        w_last     = w_flush && r_fl;
        w_z_clr    = (r_state == S_IDLE);
        w_sub      = (r_state == S_IDLE) ? bus.i_sub : r_sub;
    end

    genvar gi;
    generate
        for (gi = 0; gi < CH; gi++) begin : g_lane
            logic signed [3:0] w_xe, w_ye, w_p;
            logic              w_h;
            logic [2:0]        w_z, w_zprev, w_q;
            logic              w_t;
            logic [2:0]        r_z;
            logic              r_w;

            // Flush steps inject zero digits into both operands.
            assign w_xe = w_flush ? 4'sd0 : {{2{bus.i_x[2*gi+1]}}, bus.i_x[2*gi+1:2*gi]};
            assign w_ye = w_flush ? 4'sd0 : {{2{bus.i_y[2*gi+1]}}, bus.i_y[2*gi+1:2*gi]};
            assign w_p  = w_sub ? (w_xe - w_ye) : (w_xe + w_ye);
            assign w_h  = !w_p[3] && (w_p != 4'sd0);
            assign w_z  = w_h ? (w_p[2:0] - 3'd2) : w_p[2:0];

            // z_0 = 0 at the first step of every frame.
            assign w_zprev = w_z_clr ? 3'd0 : r_z;
            assign w_q     = w_zprev + {2'b00, w_h};
            assign w_t     = w_q[2];

            // s_k = w_k + t_{k+1}, with w in {0,1} and t meaning -1.
            assign w_s_next[2*gi+1:2*gi] = {~r_w & w_t, r_w ^ w_t};

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_z <= 3'd0;
                    r_w <= 1'b0;
                end else if (w_step) begin
                    r_z <= w_z;
                    r_w <= w_q[0];
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_o_valid <= 1'b0;
            r_o_first <= 1'b0;
            r_o_last  <= 1'b0;
            r_s       <= '0;
        end else begin
            r_o_valid <= w_out_step;
            r_o_first <= w_first;
            r_o_last  <= w_last;
            if (w_out_step)
                r_s <= w_s_next;
        end
    end

`ifdef R2ADD_P_ERRCHK_EN
    logic [CH-1:0] w_bad;
    logic          r_err;

    generate
        for (gi = 0; gi < CH; gi++) begin : g_chk
            assign w_bad[gi] = (bus.i_x[2*gi+1:2*gi] == 2'b10) ||
                               (bus.i_y[2*gi+1:2*gi] == 2'b10);
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_err <= 1'b0;
        else if (w_accept && (|w_bad))
            r_err <= 1'b1;
    end

    assign bus.o_err = r_err;
`else
    assign bus.o_err = 1'b0;
`endif

    assign bus.i_ready = w_ready;
    assign bus.o_valid = r_o_valid;
    assign bus.o_first = r_o_first;
    assign bus.o_last  = r_o_last;
    assign bus.o_s     = r_s;
endmodule

// File: tb/tb_r2add_p.sv
// Scoreboard bench for r2add_p (CH=1, N_DIGITS=4): stimulus pushes expected digits, monitor pops.
module tb_r2add_p;
    localparam int N = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    r2add_p_if #(.CH(1)) bus();

    r2add_p #(.CH(1), .N_DIGITS(N)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    logic [3:0] exp_q[$];
    logic [3:0] mon_exp;
    int         n_tests = 0;
    int         n_fail  = 0;
    bit         ignore_out = 1'b0;
    int         gap;

    // Digit 1 in bits [7:6]; -1 encoded as 2'b11. Expected s_0 in bits [9:8].
    localparam logic [7:0] ADD_X = 8'b01_00_01_00;
    localparam logic [7:0] ADD_Y = 8'b01_01_00_00;
    localparam logic [9:0] ADD_E = 10'b01_01_11_01_00;
    localparam logic [7:0] ONE_X = 8'b01_00_00_00;
    localparam logic [9:0] ZERO_E = 10'b00_00_00_00_00;
    localparam logic [7:0] POS_X = 8'b01_01_01_01;
    localparam logic [9:0] POS_E = 10'b01_01_01_01_00;
    localparam logic [7:0] NEG_X = 8'b11_11_11_11;
    localparam logic [9:0] NEG_E = 10'b11_11_11_11_00;

    task automatic check(input string name, input int act, input int req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end else begin
            $display("[TB] check %s = %0d ok", name, act);
        end
    endtask

    // Monitor: compares every presented result digit against the scoreboard.
    always @(negedge clk) begin
        if (!reset && bus.o_valid && !ignore_out) begin
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL out_unexpected: got first=%b last=%b s=%b, expected no output",
                         bus.o_first, bus.o_last, bus.o_s);
            end else begin
                mon_exp = exp_q.pop_front();
                if ({bus.o_first, bus.o_last, bus.o_s} !== mon_exp) begin
                    n_fail++;
                    $display("FAIL out_digit: got first=%b last=%b s=%b, expected first=%b last=%b s=%b",
                             bus.o_first, bus.o_last, bus.o_s, mon_exp[3], mon_exp[2], mon_exp[1:0]);
                end else begin
                    $display("[TB] out first=%b last=%b s=%b ok", bus.o_first, bus.o_last, bus.o_s);
                end
            end
        end
    end

    task automatic send_frame(input logic [7:0] x, input logic [7:0] y, input logic sub,
                              input logic [9:0] e, input int stall, input int n_dig,
                              input int n_exp, output int ready_wait);
        ready_wait = 0;
        for (int k = 0; k < n_exp; k++)
            exp_q.push_back({(k == 0), (k == N), e[9-2*k -: 2]});
        $display("[TB] frame x=%b y=%b sub=%b digits=%0d stall=%0d", x, y, sub, n_dig, stall);
        for (int d = 0; d < n_dig; d++) begin
            bus.i_valid = 1'b1;
            bus.i_x     = x[7-2*d -: 2];
            bus.i_y     = y[7-2*d -: 2];
            bus.i_sub   = (d == 0) ? sub : ~sub;
            while (!bus.i_ready && ready_wait < 20) begin
                @(posedge clk); #1;
                ready_wait++;
            end
            if (!bus.i_ready) begin
                check("ready_timeout", 0, 1);
                bus.i_valid = 1'b0;
                return;
            end
            @(posedge clk); #1;
            if (d == 1 && stall > 0) begin
                bus.i_valid = 1'b0;
                for (int s = 0; s < stall; s++) begin
                    bus.i_sub = ~bus.i_sub;
                    @(posedge clk); #1;
                    check("stall_o_valid", int'(bus.o_valid), 0);
                end
            end
        end
        bus.i_valid = 1'b0;
    endtask

    initial begin
        bus.i_valid = 1'b0;
        bus.i_sub   = 1'b0;
        bus.i_x     = 2'b00;
        bus.i_y     = 2'b00;
        reset       = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_i_ready", int'(bus.i_ready), 1);
        check("rst_o_valid", int'(bus.o_valid), 0);
        check("rst_o_first", int'(bus.o_first), 0);
        check("rst_o_last",  int'(bus.o_last), 0);
        check("rst_o_s",     int'(bus.o_s), 0);
        check("rst_o_err",   int'(bus.o_err), 0);
        reset = 1'b0;

        send_frame(ADD_X, ADD_Y, 1'b0, ADD_E, 0, N, N + 1, gap);
        send_frame(ONE_X, ONE_X, 1'b1, ZERO_E, 0, N, N + 1, gap);
        check("flush_gap_sub", gap, 2);
        send_frame(POS_X, POS_X, 1'b0, POS_E, 0, N, N + 1, gap);
        check("flush_gap_pos", gap, 2);
        send_frame(NEG_X, NEG_X, 1'b0, NEG_E, 0, N, N + 1, gap);
        check("flush_gap_neg", gap, 2);
        send_frame(ADD_X, ADD_Y, 1'b0, ADD_E, 3, N, N + 1, gap);

        // Partial frame aborted by reset after digit 3: only s_0 and s_1 emerge.
        send_frame(ADD_X, ADD_Y, 1'b0, ADD_E, 0, 3, 2, gap);
        @(negedge clk); #1;
        reset = 1'b1;
        #1;
        check("midrst_i_ready", int'(bus.i_ready), 1);
        check("midrst_o_valid", int'(bus.o_valid), 0);
        check("midrst_o_last",  int'(bus.o_last), 0);
        check("midrst_o_s",     int'(bus.o_s), 0);
        check("midrst_queue",   exp_q.size(), 0);
        @(posedge clk); #1;
        reset = 1'b0;
        send_frame(ADD_X, ADD_Y, 1'b0, ADD_E, 0, N, N + 1, gap);
        check("post_rst_gap", gap, 0);

        begin
            int t = 0;
            while (exp_q.size() != 0 && t < 20) begin
                @(posedge clk); #1;
                t++;
            end
            check("drain_queue", exp_q.size(), 0);
        end

`ifdef R2ADD_P_ERRCHK_EN
        ignore_out = 1'b1;
        check("err_before", int'(bus.o_err), 0);
        bus.i_valid = 1'b1;
        bus.i_x     = 2'b00;
        bus.i_y     = 2'b10;
        @(posedge clk); #1;
        bus.i_valid = 1'b0;
        bus.i_y     = 2'b00;
        check("err_set", int'(bus.o_err), 1);
        repeat (6) @(posedge clk);
        #1;
        check("err_sticky", int'(bus.o_err), 1);
        reset = 1'b1;
        #1;
        check("err_rst_clear", int'(bus.o_err), 0);
        @(posedge clk); #1;
        reset = 1'b0;
        ignore_out = 1'b0;
`else
        check("err_tied_zero", int'(bus.o_err), 0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/r2add_p.md
# r2add_p

Parametrised radix-2 online (MSD-first) signed-digit adder/subtractor, successor to the single-lane radix-2 online adder in the MSDF arithmetic library. It handles CH independent lanes that share one framed digit-serial handshake. Each frame carries N_DIGITS operand digits. The block inserts its own two-cycle flush, emits N_DIGITS+1 result digits with start/end markers, and adds a per-frame subtract mode. Internal transfer-digit widths are sized so no recoding step can overflow.

## Interface
- CH, 1: number of parallel lanes (≥1).
- N_DIGITS, 8: fractional digits per operand frame (≥2).
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- i_valid  in  1  digit present on i_x/i_y.
- i_ready  out  1  block accepts a digit this cycle.
- i_sub  in  1  subtract mode (x−y); sampled only with digit 1 of a frame.
- i_x  in  2*CH  lane c digit at bits [2c+1:2c]; 2-bit two's complement in {−1,0,1}.
- i_y  in  2*CH  same format as i_x.
- o_valid  out  1  o_s holds a result digit.
- o_first  out  1  o_s is s_0 (integer digit).
- o_last  out  1  o_s is s_N.
- o_s  out  2*CH  result digit per lane, {−1,0,1}.
- o_err  out  1  sticky illegal-digit flag (only with R2ADD_P_ERRCHK_EN).

## Operation
- Operands: x = Σ x_i·2^−i and y = Σ y_i·2^−i, i=1..N. Result: s = Σ s_k·2^−k, k=0..N, with s = x±y exactly.
- Stage 1, per digit: p_i = x_i ± y_i ∈ [−2,2]. If p_i ≥ 1, then h_i=1 and z_i=p_i−2. Otherwise h_i=0 and z_i=p_i. z is held as a 3-bit signed value (range −2..0).
- Stage 2: q_k = z_k + h_{k+1} ∈ [−2,1], with z_0=0 and h_{N+1}=0. If q_k < 0, then t_k=−1 and w_k=q_k+2. Otherwise t_k=0 and w_k=q_k.
- Output: s_k = w_k + t_{k+1}, with t_{N+1}=0. Always in {−1,0,1}.
- Frame control FSM:
  - IDLE: i_ready=1. On accept, sample i_sub, position=1, go to RUN.
  - RUN: i_ready=1. Each accept increments position. The accept of digit N goes to FLUSH.
  - FLUSH: i_ready=0. Two steps with implicit zero digits, then IDLE.
- Step definition:
  - Step = accept in IDLE/RUN, or any FLUSH cycle.
  - The pipeline advances only on a step.
  - In RUN with i_valid=0, all state holds (stall) and o_valid=0.
- Output timing: s_k is registered on step k+2, k=0..N. o_valid is high the cycle after each such step. o_first marks k=0 and o_last marks k=N.
- Throughput: one frame per N+2 cycles, with no stalls.
- o_s has no back-pressure; the consumer must take each digit while o_valid=1.
- i_sub is ignored after digit 1 and applies to all lanes for the whole frame.
- Input encoding 2'b10 is illegal. The arithmetic treats it as −2, so results become undefined.

## Timing
- Reset values:
  - i_ready=1, o_valid=0, o_first=0, o_last=0, o_s=0, o_err=0.
  - FSM=IDLE; all h/z/w/t pipeline registers = 0.
- Latency: digit i accepted at edge E → s_{i−2} visible after edge E (registered), for i ≥ 2. Online delay is 2 and there is one output register.
- Last result digit s_N is visible after the second FLUSH edge. i_ready returns to 1 in that same cycle.
- An accept in that cycle starts the next frame. There is no bubble beyond the two flush cycles.
- reset mid-frame: immediate return to the reset values above; partial frame discarded; no o_last emitted.
- i_valid during FLUSH: not accepted, because i_ready=0.

## Configuration
- R2ADD_P_ERRCHK_EN defined:
  - o_err is set the cycle after any accepted digit equal to 2'b10 on any lane of i_x or i_y.
  - o_err is cleared only by reset.
- R2ADD_P_ERRCHK_EN undefined:
  - o_err is tied 0 and no check logic is built.
  - Datapath behaviour is identical in both builds.

## Test plan
All cases use CH=1, N_DIGITS=4, and back-to-back i_valid unless stated otherwise.
- Add: x=[1,0,1,0] (0.625), y=[1,1,0,0] (0.75), i_sub=0 → o_s = 1,1,−1,1,0 (1.375). o_first on the 1st digit, o_last on the 5th; o_valid for 5 consecutive cycles starting the cycle after digit 2.
- Subtract: x=y=[1,0,0,0], i_sub=1 → o_s = 0,0,0,0,0.
- Extremes: x=y=[1,1,1,1] → 1,1,1,1,0 (1.875). Then immediately x=y=[−1,−1,−1,−1] → −1,−1,−1,−1,0 (−1.875). i_ready is low exactly 2 cycles between frames.
- Stall: repeat the add case with i_valid=0 for 3 cycles after digit 2 → identical o_s sequence, o_valid gaps aligned with the stall, i_sub toggled during the stall has no effect.
- Reset: assert reset after digit 3 → all outputs 0 next cycle and i_ready=1. The next frame's result is correct.
- Errcheck (macro defined): digit 2'b10 on i_y → o_err=1 the following cycle; it stays 1 until reset. With the macro undefined, o_err stays 0.
